// File: rtl/tube_host_master.sv
// Host-side Tube bus initiator: turns single-byte register commands into host bus cycles.
// It polls the status byte for R1-R4 before the data cycle, giving up after POLL_LIMIT polls.
module tube_host_master #(
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic       h_phi2,
    input  logic       h_rst_b,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_ctrl,
    input  logic [1:0] cmd_reg,
    input  logic       cmd_write,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [2:0] h_addr,
    output logic       h_cs_b,
    output logic       h_rdnw,
    output logic [7:0] h_data_out,
    input  logic [7:0] h_data_in,
    input  logic       h_irq_b,
    output logic       host_irq
);

    typedef enum logic [1:0] {StIdle, StPoll, StData} state_e;

    // A zero limit disables the abort path entirely.
    localparam bit         PollForever = (POLL_LIMIT == 0);
    localparam logic [7:0] PollLast    = 8'(POLL_LIMIT - 1);

    state_e     state_q, state_d;
    logic [7:0] poll_cnt_q, poll_cnt_d;
    logic [1:0] cmd_reg_q, cmd_reg_d;
    logic       cmd_write_q, cmd_write_d;
    logic [7:0] cmd_wdata_q, cmd_wdata_d;
    logic [2:0] h_addr_q, h_addr_d;
    logic       h_cs_b_q, h_cs_b_d;
    logic       h_rdnw_q, h_rdnw_d;
    logic [7:0] h_data_out_q, h_data_out_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_err_q, rsp_err_d;
    logic       host_irq_q;
    logic       poll_ok;

    // Writes wait for "not full" (bit 6), reads for "data available" (bit 7).
    assign poll_ok = cmd_write_q ? h_data_in[6] : h_data_in[7];

    always_comb begin
        state_d      = state_q;
        poll_cnt_d   = poll_cnt_q;
        cmd_reg_d    = cmd_reg_q;
        cmd_write_d  = cmd_write_q;
        cmd_wdata_d  = cmd_wdata_q;
        h_addr_d     = h_addr_q;
        h_cs_b_d     = h_cs_b_q;
        h_rdnw_d     = h_rdnw_q;
        h_data_out_d = h_data_out_q;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = 8'h00;
        rsp_err_d    = 1'b0;

        case (state_q)
            StIdle: begin
                h_cs_b_d = 1'b1;
                h_rdnw_d = 1'b1;
                if (cmd_valid) begin
                    cmd_reg_d   = cmd_reg;
                    cmd_write_d = cmd_write;
                    cmd_wdata_d = cmd_wdata;
                    poll_cnt_d  = 8'd0;
                    h_cs_b_d    = 1'b0;
                    if (cmd_ctrl) begin
                        state_d  = StData;
                        h_addr_d = 3'd0;
                        h_rdnw_d = !cmd_write;
                        if (cmd_write) begin
                            h_data_out_d = cmd_wdata;
                        end
                    end else begin
                        state_d  = StPoll;
                        h_addr_d = {cmd_reg, 1'b0};
                        h_rdnw_d = 1'b1;
                    end
                end
            end
            StPoll: begin
                if (poll_ok) begin
                    state_d  = StData;
                    h_addr_d = {cmd_reg_q, 1'b1};
                    h_rdnw_d = !cmd_write_q;
                    if (cmd_write_q) begin
                        h_data_out_d = cmd_wdata_q;
                    end
                end else if (!PollForever && (poll_cnt_q == PollLast)) begin
                    state_d     = StIdle;
                    h_cs_b_d    = 1'b1;
                    h_rdnw_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    poll_cnt_d = poll_cnt_q + 8'd1;
                end
            end
            StData: begin
                state_d     = StIdle;
                h_cs_b_d    = 1'b1;
                h_rdnw_d    = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_data_d  = cmd_write_q ? 8'h00 : h_data_in;
            end
            default: begin
                state_d  = StIdle;
                h_cs_b_d = 1'b1;
                h_rdnw_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge h_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state_q      <= StIdle;
            poll_cnt_q   <= 8'd0;
            cmd_reg_q    <= 2'd0;
            cmd_write_q  <= 1'b0;
            cmd_wdata_q  <= 8'h00;
            h_addr_q     <= 3'd0;
            h_cs_b_q     <= 1'b1;
            h_rdnw_q     <= 1'b1;
            h_data_out_q <= 8'h00;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 8'h00;
            rsp_err_q    <= 1'b0;
            host_irq_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            poll_cnt_q   <= poll_cnt_d;
            cmd_reg_q    <= cmd_reg_d;
            cmd_write_q  <= cmd_write_d;
            cmd_wdata_q  <= cmd_wdata_d;
            h_addr_q     <= h_addr_d;
            h_cs_b_q     <= h_cs_b_d;
            h_rdnw_q     <= h_rdnw_d;
            h_data_out_q <= h_data_out_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            host_irq_q   <= !h_irq_b;
        end
    end

    assign cmd_ready  = (state_q == StIdle);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign h_addr     = h_addr_q;
    assign h_cs_b     = h_cs_b_q;
    assign h_rdnw     = h_rdnw_q;
    assign h_data_out = h_data_out_q;
    assign host_irq   = host_irq_q;

endmodule

// File: tb/tb_tube_host_master.sv
// Directed and randomized bench for tube_host_master; expected bus cycles are derived
// from the status bytes fed in, using the poll/abort rules directly.
module tb_tube_host_master;

    localparam int unsigned LIMIT = 4;

    logic       h_phi2 = 1'b0;
    logic       h_rst_b;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_ctrl = 1'b0;
    logic [1:0] cmd_reg = 2'd0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [2:0] h_addr;
    logic       h_cs_b;
    logic       h_rdnw;
    logic [7:0] h_data_out;
    logic [7:0] h_data_in = 8'h00;
    logic       h_irq_b = 1'b1;
    logic       host_irq;

    int tests = 0;
    int fails = 0;
    logic [7:0] sq[$];

    tube_host_master #(.POLL_LIMIT(LIMIT)) dut (
        .h_phi2    (h_phi2),
        .h_rst_b   (h_rst_b),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ctrl  (cmd_ctrl),
        .cmd_reg   (cmd_reg),
        .cmd_write (cmd_write),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .h_addr    (h_addr),
        .h_cs_b    (h_cs_b),
        .h_rdnw    (h_rdnw),
        .h_data_out(h_data_out),
        .h_data_in (h_data_in),
        .h_irq_b   (h_irq_b),
        .host_irq  (host_irq)
    );

    always #5 h_phi2 = ~h_phi2;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge h_phi2);
        #1;
    endtask

    // Entered with the DUT ready (idle or in a response cycle); leaves it in the response cycle.
    task automatic run_cmd(input bit ctrl, input logic [1:0] r, input bit wr,
                           input logic [7:0] wd, input logic [7:0] dat);
        int         polls;
        bit         has_data;
        logic [7:0] mask;
        logic [2:0] daddr;

        mask     = wr ? 8'h40 : 8'h80;
        polls    = 0;
        has_data = 1'b1;
        if (!ctrl) begin
            has_data = 1'b0;
            foreach (sq[i]) begin
                polls++;
                if ((sq[i] & mask) != 8'h00) begin
                    has_data = 1'b1;
                    break;
                end
                if (polls == LIMIT) break;
            end
        end
        daddr = ctrl ? 3'd0 : {r, 1'b1};

        chk1("ready_before", cmd_ready, 1'b1);
        chk1("cs_before", h_cs_b, 1'b1);
        cmd_valid = 1'b1;
        cmd_ctrl  = ctrl;
        cmd_reg   = r;
        cmd_write = wr;
        cmd_wdata = wd;
        tick();
        cmd_valid = 1'b0;
        cmd_ctrl  = 1'($urandom);
        cmd_reg   = 2'($urandom);
        cmd_write = 1'($urandom);
        cmd_wdata = 8'($urandom);

        for (int i = 0; i < polls; i++) begin
            chk1("poll_cs", h_cs_b, 1'b0);
            chk8("poll_addr", {5'd0, h_addr}, {5'd0, r, 1'b0});
            chk1("poll_rdnw", h_rdnw, 1'b1);
            chk1("poll_rsp", rsp_valid, 1'b0);
            chk1("poll_ready", cmd_ready, 1'b0);
            h_data_in = sq[i];
            tick();
            h_data_in = 8'($urandom);
        end
        if (has_data) begin
            chk1("data_cs", h_cs_b, 1'b0);
            chk8("data_addr", {5'd0, h_addr}, {5'd0, daddr});
            chk1("data_rdnw", h_rdnw, !wr);
            chk1("data_rsp", rsp_valid, 1'b0);
            if (wr) chk8("data_out", h_data_out, wd);
            h_data_in = dat;
            tick();
            h_data_in = 8'($urandom);
        end
        chk1("rsp_valid", rsp_valid, 1'b1);
        chk1("rsp_err", rsp_err, !has_data);
        chk8("rsp_data", rsp_data, (has_data && !wr) ? dat : 8'h00);
        chk1("rsp_cs", h_cs_b, 1'b1);
        chk1("rsp_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        h_rst_b = 1'b1;
        #2;
        h_rst_b = 1'b0;
        #1;
        chk1("rst_cs", h_cs_b, 1'b1);
        chk1("rst_rdnw", h_rdnw, 1'b1);
        chk8("rst_addr", {5'd0, h_addr}, 8'h00);
        chk8("rst_dout", h_data_out, 8'h00);
        chk1("rst_rsp", rsp_valid, 1'b0);
        chk8("rst_rdata", rsp_data, 8'h00);
        chk1("rst_err", rsp_err, 1'b0);
        chk1("rst_irq", host_irq, 1'b0);
        chk1("rst_ready", cmd_ready, 1'b1);
        @(negedge h_phi2);
        h_rst_b = 1'b1;
        tick();

        // Control write
        sq = {};
        run_cmd(1'b1, 2'd0, 1'b1, 8'h92, 8'h00);
        tick();
        chk1("gap_cs", h_cs_b, 1'b1);
        chk1("gap_rsp", rsp_valid, 1'b0);

        // R1 read with two failing polls
        sq = {8'h3F, 8'h3F, 8'hFF};
        run_cmd(1'b0, 2'd0, 1'b0, 8'h00, 8'h5A);
        // R4 write accepted back-to-back in the previous response cycle
        sq = {8'h80, 8'hC0};
        run_cmd(1'b0, 2'd3, 1'b1, 8'h11, 8'h77);
        // R2 read abort
        sq = {8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F};
        run_cmd(1'b0, 2'd1, 1'b0, 8'h00, 8'h33);
        // Control read returns the raw status
        sq = {};
        run_cmd(1'b1, 2'd2, 1'b0, 8'h00, 8'hA5);
        tick();

        // Reset during polling
        cmd_valid = 1'b1;
        cmd_ctrl  = 1'b0;
        cmd_reg   = 2'd0;
        cmd_write = 1'b0;
        tick();
        cmd_valid = 1'b0;
        h_data_in = 8'h3F;
        tick();
        chk1("prerst_cs", h_cs_b, 1'b0);
        h_rst_b = 1'b0;
        #1;
        chk1("midrst_cs", h_cs_b, 1'b1);
        chk1("midrst_rsp", rsp_valid, 1'b0);
        chk1("midrst_ready", cmd_ready, 1'b1);
        tick();
        chk1("midrst_rsp2", rsp_valid, 1'b0);
        @(negedge h_phi2);
        h_rst_b = 1'b1;
        tick();
        chk1("postrst_ready", cmd_ready, 1'b1);
        chk1("postrst_cs", h_cs_b, 1'b1);
        chk1("postrst_rsp", rsp_valid, 1'b0);
        h_irq_b = 1'b0;
        tick();
        chk1("irq_set", host_irq, 1'b1);
        h_irq_b = 1'b1;
        tick();
        chk1("irq_clr", host_irq, 1'b0);

        // Randomized commands, sometimes separated by idle cycles
        for (int n = 0; n < 40; n++) begin
            bit         c;
            bit         w;
            int         nfail;
            logic [7:0] m;
            c     = ($urandom_range(0, 3) == 0);
            w     = 1'($urandom);
            m     = w ? 8'h40 : 8'h80;
            nfail = $urandom_range(0, 5);
            sq    = {};
            for (int i = 0; i < nfail; i++) sq.push_back(8'($urandom) & ~m);
            sq.push_back(8'($urandom) | m);
            run_cmd(c, 2'($urandom), w, 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                tick();
                chk1("rnd_gap_rsp", rsp_valid, 1'b0);
                chk1("rnd_gap_cs", h_cs_b, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
